// File: rtl/muldiv_sequencer_if.sv
// Request/write-back bundle between decode and the multiply/divide sequencer.
interface muldiv_sequencer_if #(
    parameter int DATA_WIDTH          = 16,
    parameter int REG_ADDR_WIDTH      = 4,
    parameter int FUNCTION_CODE_WIDTH = 4
);
    // Handshake: decode holds start with a MUL/DIV func_code and its operands;
    // the request is taken on the rising edge where the sequencer is IDLE,
    // and stall (combinational) holds the pipeline from that cycle until
    // the single done/write-back cycle, in which stall is low.
    logic                           start;
    logic [FUNCTION_CODE_WIDTH-1:0] func_code;
    logic [DATA_WIDTH-1:0]          op_a;
    logic [DATA_WIDTH-1:0]          op_b;
    logic [REG_ADDR_WIDTH-1:0]      dest_in;
    logic                           stall;
    logic                           busy;
    logic                           done;
    logic [DATA_WIDTH-1:0]          result_lo;
    logic [DATA_WIDTH-1:0]          result_hi;
    logic [REG_ADDR_WIDTH-1:0]      dest_out;
    logic                           write_reg;
    logic                           write_r0;
    logic                           exc_alu;
    logic [1:0]                     state_dbg;

    modport master (
        output start, func_code, op_a, op_b, dest_in,
        input  stall, busy, done, result_lo, result_hi, dest_out,
               write_reg, write_r0, exc_alu, state_dbg
    );

    modport slave (
        input  start, func_code, op_a, op_b, dest_in,
        output stall, busy, done, result_lo, result_hi, dest_out,
               write_reg, write_r0, exc_alu, state_dbg
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per clock,
// with a single write-back cycle and a divide-by-zero exception.
module muldiv_sequencer #(
    parameter int DATA_WIDTH          = 16,
    parameter int REG_ADDR_WIDTH      = 4,
    parameter int FUNCTION_CODE_WIDTH = 4,
    parameter int CNT_WIDTH           = 5
) (
    input logic               clk,
    input logic               rst_n,
    muldiv_sequencer_if.slave bus
);
    localparam logic [FUNCTION_CODE_WIDTH-1:0] FUNC_MUL = FUNCTION_CODE_WIDTH'(1);
    localparam logic [FUNCTION_CODE_WIDTH-1:0] FUNC_DIV = FUNCTION_CODE_WIDTH'(2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic                      is_div_q, is_div_d;
    // acc: product high half / partial remainder
    // mq:  multiplier being shifted out / dividend shifted out, quotient shifted in
    // opnd: multiplicand / divisor
    logic [DATA_WIDTH-1:0]     acc_q, acc_d;
    logic [DATA_WIDTH-1:0]     mq_q, mq_d;
    logic [DATA_WIDTH-1:0]     opnd_q, opnd_d;
    logic [DATA_WIDTH-1:0]     result_lo_q, result_lo_d;
    logic [DATA_WIDTH-1:0]     result_hi_q, result_hi_d;
    logic [REG_ADDR_WIDTH-1:0] dest_out_q, dest_out_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      write_reg_q, write_reg_d;
    logic                      write_r0_q, write_r0_d;
    logic                      exc_q, exc_d;

    logic                      req_is_mul, req_is_div, accept, stall;
    logic [DATA_WIDTH:0]       mul_sum, mul_add, rem_sh, div_diff;
    logic [DATA_WIDTH-1:0]     step_acc, step_mq;

    // One iteration of whichever algorithm is in flight.
    always_comb begin
        mul_sum  = {1'b0, acc_q} + {1'b0, opnd_q};
        mul_add  = mq_q[0] ? mul_sum : {1'b0, acc_q};
        rem_sh   = {acc_q, mq_q[DATA_WIDTH-1]};
        div_diff = rem_sh - {1'b0, opnd_q};
        step_acc = mul_add[DATA_WIDTH:1];
        step_mq  = {mul_add[0], mq_q[DATA_WIDTH-1:1]};
        if (is_div_q) begin
            // Borrow out of the subtraction means the trial did not fit: restore.
            step_acc = div_diff[DATA_WIDTH] ? rem_sh[DATA_WIDTH-1:0] : div_diff[DATA_WIDTH-1:0];
            step_mq  = {mq_q[DATA_WIDTH-2:0], ~div_diff[DATA_WIDTH]};
        end
    end

    // Next-state and output decode; everything holds unless changed below.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_div_d    = is_div_q;
        acc_d       = acc_q;
        mq_d        = mq_q;
        opnd_d      = opnd_q;
        result_lo_d = result_lo_q;
        result_hi_d = result_hi_q;
        dest_out_d  = dest_out_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        write_reg_d = 1'b0;
        write_r0_d  = 1'b0;
        exc_d       = 1'b0;

        req_is_mul = (bus.func_code == FUNC_MUL);
        req_is_div = (bus.func_code == FUNC_DIV);
        accept     = (state_q == S_IDLE) && bus.start && (req_is_mul || req_is_div);
        stall      = accept || (state_q == S_BUSY);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    is_div_d   = req_is_div;
                    dest_out_d = bus.dest_in;
                    cnt_d      = CNT_WIDTH'(DATA_WIDTH - 1);
                    if (req_is_div && (bus.op_b == '0)) begin
                        // Divide by zero skips the iterations entirely.
                        state_d     = S_DONE;
                        done_d      = 1'b1;
                        exc_d       = 1'b1;
                        result_lo_d = '0;
                        result_hi_d = '0;
                    end else begin
                        state_d = S_BUSY;
                        busy_d  = 1'b1;
                        acc_d   = '0;
                        opnd_d  = req_is_div ? bus.op_b : bus.op_a;
                        mq_d    = req_is_div ? bus.op_a : bus.op_b;
                    end
                end
            end
            S_BUSY: begin
                acc_d = step_acc;
                mq_d  = step_mq;
                if (cnt_q == '0) begin
                    // Both algorithms leave {high/remainder, low/quotient} in {acc, mq}.
                    state_d     = S_DONE;
                    result_hi_d = step_acc;
                    result_lo_d = step_mq;
                    done_d      = 1'b1;
                    write_reg_d = 1'b1;
                    write_r0_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                    cnt_d  = cnt_q - CNT_WIDTH'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            is_div_q    <= 1'b0;
            acc_q       <= '0;
            mq_q        <= '0;
            opnd_q      <= '0;
            result_lo_q <= '0;
            result_hi_q <= '0;
            dest_out_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            write_reg_q <= 1'b0;
            write_r0_q  <= 1'b0;
            exc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_div_q    <= is_div_d;
            acc_q       <= acc_d;
            mq_q        <= mq_d;
            opnd_q      <= opnd_d;
            result_lo_q <= result_lo_d;
            result_hi_q <= result_hi_d;
            dest_out_q  <= dest_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            write_reg_q <= write_reg_d;
            write_r0_q  <= write_r0_d;
            exc_q       <= exc_d;
        end
    end

    assign bus.stall     = stall;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result_lo = result_lo_q;
    assign bus.result_hi = result_hi_q;
    assign bus.dest_out  = dest_out_q;
    assign bus.write_reg = write_reg_q;
    assign bus.write_r0  = write_r0_q;
    assign bus.exc_alu   = exc_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed bench for muldiv_sequencer with a scoreboard of write-backs.
module tb_muldiv_sequencer;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int FW = 4;
    localparam int CW = 5;
    // Expected write-back: {exc_alu, write_reg, write_r0, dest_out, result_hi, result_lo}
    localparam int EW = 3 + AW + 2 * DW;

    logic          clk;
    logic          rst_n;
    int            tests;
    int            fails;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_exp;
    logic [EW-1:0] mon_got;

    muldiv_sequencer_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .FUNCTION_CODE_WIDTH(FW)) bus ();

    muldiv_sequencer #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .FUNCTION_CODE_WIDTH(FW), .CNT_WIDTH(CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on the operands.
    function automatic logic [EW-1:0] model(input logic is_div, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b, input logic [AW-1:0] d);
        logic [2*DW-1:0] p;
        if (!is_div) begin
            p = (2*DW)'(a) * (2*DW)'(b);
            return {1'b0, 1'b1, 1'b1, d, p};
        end else if (b == '0) begin
            return {1'b1, 1'b0, 1'b0, d, {(2*DW){1'b0}}};
        end
        return {1'b0, 1'b1, 1'b1, d, DW'(a % b), DW'(a / b)};
    endfunction

    // Monitor: every done cycle is one write-back, compared against the queue head.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            mon_got = {bus.exc_alu, bus.write_reg, bus.write_r0, bus.dest_out,
                       bus.result_hi, bus.result_lo};
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got 0x%0h expected no write-back", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                check("writeback", 64'(mon_got), 64'(mon_exp));
            end
        end
    end

    // Issue one operation (at posedge+1) and follow it to the IDLE cycle after done.
    task automatic run_op(input logic is_div, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [AW-1:0] d, input bit poke);
        int  stall_n;
        int  busy_n;
        bit  seen;
        bit  div0;
        logic [EW-1:0] e;
        div0          = is_div && (b == '0);
        e             = model(is_div, a, b, d);
        bus.start     = 1'b1;
        bus.func_code = is_div ? FW'(2) : FW'(1);
        bus.op_a      = a;
        bus.op_b      = b;
        bus.dest_in   = d;
        exp_q.push_back(e);
        stall_n = 0;
        busy_n  = 0;
        seen    = 1'b0;
        for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                check("stall_in_done", 64'(bus.stall), 64'(0));
            end else begin
                if (bus.stall) stall_n++;
                if (bus.busy) busy_n++;
                @(posedge clk);
                #1;
                // A new request while busy must be ignored.
                bus.start     = poke && (cyc >= 2) && (cyc < 8);
                bus.func_code = FW'(1);
                bus.op_a      = DW'($urandom);
                bus.op_b      = DW'($urandom);
                bus.dest_in   = AW'($urandom);
            end
        end
        bus.start = 1'b0;
        if (!seen) begin
            check("done_timeout", 64'(0), 64'(1));
            exp_q.delete();
        end else begin
            check("stall_cycles", 64'(stall_n), div0 ? 64'(1) : 64'(17));
            check("busy_cycles", 64'(busy_n), div0 ? 64'(0) : 64'(16));
        end
        @(negedge clk);
        check("after_done_ctrl",
              64'({bus.done, bus.exc_alu, bus.write_reg, bus.write_r0, bus.busy, bus.state_dbg}),
              64'(0));
        check("result_hold", 64'({bus.dest_out, bus.result_hi, bus.result_lo}),
              64'(e[AW+2*DW-1:0]));
        @(posedge clk);
        #1;
    endtask

    // Request with a function code that is neither MUL nor DIV.
    task automatic bad_func(input logic [FW-1:0] f);
        bus.start     = 1'b1;
        bus.func_code = f;
        bus.op_a      = DW'($urandom);
        bus.op_b      = DW'($urandom);
        bus.dest_in   = AW'($urandom);
        @(negedge clk);
        check("bad_func_stall", 64'(bus.stall), 64'(0));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("bad_func_state", 64'({bus.state_dbg, bus.busy, bus.done}), 64'(0));
        @(posedge clk);
        #1;
    endtask

    // Main sequence
    initial begin
        logic [FW-1:0] f;
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;
        bit            any_done;
        tests         = 0;
        fails         = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.func_code = '0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.dest_in   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              64'({bus.stall, bus.busy, bus.done, bus.write_reg, bus.write_r0, bus.exc_alu,
                   bus.state_dbg, bus.dest_out}), 64'(0));
        check("reset_results", 64'({bus.result_hi, bus.result_lo}), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed operations
        run_op(1'b0, 16'd3, 16'd5, 4'd4, 1'b0);
        run_op(1'b0, 16'hFFFF, 16'hFFFF, 4'd1, 1'b0);
        run_op(1'b0, 16'h0000, 16'h1234, 4'd2, 1'b0);
        run_op(1'b1, 16'd100, 16'd7, 4'd3, 1'b0);
        run_op(1'b1, 16'd5, 16'd9, 4'd5, 1'b0);
        run_op(1'b1, 16'hFFFF, 16'd1, 4'd6, 1'b0);
        run_op(1'b1, 16'd42, 16'd0, 4'd7, 1'b0);
        run_op(1'b0, 16'd1234, 16'd77, 4'd8, 1'b1);

        // Ignored function codes
        bad_func(4'b1111);
        bad_func(4'b0000);
        bad_func(4'b0011);
        f = FW'($urandom_range(3, 15));
        bad_func(f);

        // Randomized mix
        for (int i = 0; i < 40; i++) begin
            ra = DW'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? DW'(0) : DW'($urandom);
            if ($urandom_range(0, 3) == 0) rb = DW'($urandom_range(1, 15));
            run_op(1'($urandom_range(0, 1)), ra, rb, AW'($urandom), 1'($urandom_range(0, 1)));
        end
        run_op(1'b0, 16'd9, 16'd11, 4'd9, 1'b0);

        // Reset in the middle of a divide
        bus.start     = 1'b1;
        bus.func_code = FW'(2);
        bus.op_a      = 16'd1000;
        bus.op_b      = 16'd13;
        bus.dest_in   = 4'd10;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midop_reset_ctrl",
              64'({bus.stall, bus.busy, bus.done, bus.write_reg, bus.write_r0, bus.exc_alu,
                   bus.state_dbg, bus.dest_out}), 64'(0));
        check("midop_reset_results", 64'({bus.result_hi, bus.result_lo}), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        any_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) any_done = 1'b1;
        end
        check("no_done_after_reset", 64'(any_done), 64'(0));
        check("idle_after_reset", 64'(bus.state_dbg), 64'(0));
        @(posedge clk);
        #1;
        run_op(1'b0, 16'd6, 16'd7, 4'd11, 1'b0);

        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the MUL and DIV ALU functions (opcode ALU, func 0001/0010).
- Runs an iterative unsigned shift-add multiplier or restoring divider, one bit per clock.
- Stalls the pipeline while busy, then issues one write-back cycle: primary result to the destination register, secondary result to R0.
- Flags divide-by-zero on the ALU exception line that feeds the central control unit's halt logic.

Parameters:
- DATA_WIDTH, 16, operand and result width.
- REG_ADDR_WIDTH, 4, destination register index width.
- FUNCTION_CODE_WIDTH, 4, function code width.
- CNT_WIDTH, 5, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request from decode; valid only with a MUL or DIV func_code.
- func_code  in  FUNCTION_CODE_WIDTH  0001 = MUL, 0010 = DIV.
- op_a  in  DATA_WIDTH  multiplicand / dividend.
- op_b  in  DATA_WIDTH  multiplier / divisor.
- dest_in  in  REG_ADDR_WIDTH  destination register index.
- stall  out  1  combinational pipeline hold.
- busy  out  1  registered; high in BUSY state.
- done  out  1  registered one-cycle completion pulse.
- result_lo  out  DATA_WIDTH  product low half / quotient.
- result_hi  out  DATA_WIDTH  product high half / remainder.
- dest_out  out  REG_ADDR_WIDTH  latched destination index.
- write_reg  out  1  write result_lo to dest_out, during done only.
- write_r0  out  1  write result_hi to R0, during done only.
- exc_alu  out  1  divide-by-zero exception, during done only.

Behaviour:
- Reset (async, rst_n = 0):
  - State goes to IDLE.
  - done, busy, write_reg, write_r0, exc_alu = 0.
  - result_lo, result_hi, dest_out and the counter = 0.
  - Applies immediately, including mid-operation; the in-flight operation is discarded with no write and no exception.
- States:
  - IDLE: accepts a request.
  - BUSY: iterates.
  - DONE: one cycle of write-back.
- Accept condition: in IDLE, start = 1 and func_code is MUL or DIV.
  - Any other func_code with start is ignored: no stall, no state change.
- Accepting edge E0:
  - Latch op_a, op_b, dest_in and the op type.
  - Load the counter with DATA_WIDTH-1.
  - Go to BUSY.
  - Exception: DIV with op_b = 0 goes directly to DONE with exc_alu = 1, write_reg = 0, write_r0 = 0, results 0.
- BUSY:
  - Each edge performs one iteration.
  - At the edge where the counter = 0, load the final results, set done, write_reg and write_r0, and go to DONE.
  - Otherwise decrement the counter.
  - Iterations occur at E1..E(DATA_WIDTH); done is visible in the cycle after E(DATA_WIDTH).
- MUL: unsigned; {result_hi, result_lo} = op_a * op_b, full 2*DATA_WIDTH product, no truncation.
- DIV: unsigned restoring division; result_lo = floor(op_a / op_b), result_hi = op_a mod op_b.
- DONE:
  - done = 1 for exactly one cycle; write_reg = write_r0 = 1 unless an exception occurred.
  - Next edge: return to IDLE and clear done, write_reg, write_r0 and exc_alu.
  - result_lo, result_hi and dest_out hold until the next accept.
- stall is combinational:
  - High when (IDLE and accept condition true) or state = BUSY.
  - Low in DONE, so the stalled instruction retires with the write-back.
- start while BUSY or DONE is ignored; operands are never re-sampled mid-operation.
- A back-to-back request is accepted no earlier than the IDLE cycle after DONE.
- Operand inputs may change freely after E0.

Test Plan:
- Reset, then MUL op_a = 3, op_b = 5, dest_in = 4 -> stall high for 17 cycles; after 16 iteration edges, done = 1 with result_lo = 15, result_hi = 0, dest_out = 4, write_reg = write_r0 = 1 for one cycle.
- MUL 0xFFFF * 0xFFFF -> result_lo = 0x0001, result_hi = 0xFFFE; also check 0 * 0x1234 -> 0, 0.
- DIV 100 / 7 -> result_lo = 14, result_hi = 2; also check 5 / 9 -> 0, 5 and 0xFFFF / 1 -> 0xFFFF, 0.
- DIV 42 / 0 -> DONE the cycle after E0 with exc_alu = 1, write_reg = write_r0 = 0 and no BUSY cycles; next cycle IDLE with exc_alu = 0.
- start with func_code = 1111 -> no stall, no state change; start with a new MUL while BUSY is ignored and the original result is unaffected.
- Assert rst_n low at iteration 8 of a DIV -> all outputs 0 immediately; after release, IDLE with no done pulse; a fresh MUL 6 * 7 gives 42.
